// File: rtl/eight_to_three_encoder_pkg.sv
// eight_to_three_encoder_pkg: shared widths, FSM states and helpers
// for the sequential 8-to-3 priority encoder.
package eight_to_three_encoder_pkg;

    localparam int REQ_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Re-expand a code to its request line, as the downstream decoder does.
    function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] c);
        logic [REQ_W-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/eight_to_three_encoder_prio.sv
// eight_to_three_encoder_prio: combinational priority encoder,
// highest set bit wins; found flags a non-empty input.
module eight_to_three_encoder_prio
    import eight_to_three_encoder_pkg::*;
(
    input  logic [REQ_W-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              found
);

    // Scan upward so the highest set bit is the last assignment.
    always_comb begin
        code  = '0;
        found = 1'b0;
        for (int i = 0; i < REQ_W; i++) begin
            if (req[i]) begin
                code  = i[CODE_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eight_to_three_encoder.sv
// eight_to_three_encoder: sticky pending register, IDLE/GRANT FSM
// and registered Code/Valid with Valid/Ack handshake.
module eight_to_three_encoder
    import eight_to_three_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              E,
    input  logic [REQ_W-1:0]  Req,
    input  logic              Ack,
    output logic [CODE_W-1:0] Code,
    output logic              Valid,
    output logic [REQ_W-1:0]  Pending
);

    state_t            state;
    logic              served;
    logic [REQ_W-1:0]  clr;
    logic [REQ_W-1:0]  cap;
    logic [REQ_W-1:0]  next;
    logic [CODE_W-1:0] pend_code;
    logic              pend_found;
    logic [CODE_W-1:0] next_code;
    logic              next_found;

    // Handshake terms; next ignores same-edge capture by design.
    always_comb begin
        served = Valid && Ack;
        clr    = served ? onehot(Code) : '0;
        cap    = E ? Req : '0;
        next   = Pending & ~onehot(Code);
    end

    eight_to_three_encoder_prio u_prio_pend (
        .req   (Pending),
        .code  (pend_code),
        .found (pend_found)
    );

    eight_to_three_encoder_prio u_prio_next (
        .req   (next),
        .code  (next_code),
        .found (next_found)
    );

    // Sticky pending: clear the served bit, set wins on collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Pending <= '0;
        end else begin
            Pending <= (Pending & ~clr) | cap;
        end
    end

    // Grant FSM with registered Code and Valid; no preemption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            Code  <= '0;
            Valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (E && pend_found) begin
                        state <= GRANT;
                        Code  <= pend_code;
                        Valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (Ack) begin
                        if (E && next_found) begin
                            Code <= next_code;
                        end else begin
                            state <= IDLE;
                            Valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eight_to_three_encoder.sv
// tb_eight_to_three_encoder: table-driven directed vectors plus
// hand-written reset and idle-Ack sequences.
module tb_eight_to_three_encoder;

    logic       clk;
    logic       reset;
    logic       E;
    logic [7:0] Req;
    logic       Ack;
    logic [2:0] Code;
    logic       Valid;
    logic [7:0] Pending;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       e;
        logic [7:0] req;
        logic       ack;
        logic [7:0] exp_pend;
        logic       exp_valid;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[$];

    eight_to_three_encoder dut (
        .clk     (clk),
        .reset   (reset),
        .E       (E),
        .Req     (Req),
        .Ack     (Ack),
        .Code    (Code),
        .Valid   (Valid),
        .Pending (Pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string n, input logic [7:0] got,
                          input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic e, input logic [7:0] r,
                       input logic a, input logic [7:0] p, input logic v,
                       input logic [2:0] c);
        vec_t t;
        t.name      = n;
        t.e         = e;
        t.req       = r;
        t.ack       = a;
        t.exp_pend  = p;
        t.exp_valid = v;
        t.exp_code  = c;
        vecs.push_back(t);
    endtask

    initial begin
        // single request
        add("single_cap",   1, 8'h08, 0, 8'h08, 0, 3'd0);
        add("single_pres",  1, 8'h00, 0, 8'h08, 1, 3'd3);
        add("single_ack",   1, 8'h00, 1, 8'h00, 0, 3'd0);
        // priority and back-to-back
        add("prio_cap",     1, 8'hA1, 0, 8'hA1, 0, 3'd0);
        add("prio_7",       1, 8'h00, 1, 8'hA1, 1, 3'd7);
        add("prio_5",       1, 8'h00, 1, 8'h21, 1, 3'd5);
        add("prio_0",       1, 8'h00, 1, 8'h01, 1, 3'd0);
        add("prio_done",    1, 8'h00, 1, 8'h00, 0, 3'd0);
        // no preemption, E=0 holds presentation
        add("np_cap",       1, 8'h04, 0, 8'h04, 0, 3'd0);
        add("np_pres",      1, 8'h00, 0, 8'h04, 1, 3'd2);
        add("np_higher",    1, 8'h40, 0, 8'h44, 1, 3'd2);
        add("np_e0_a",      0, 8'h80, 0, 8'h44, 1, 3'd2);
        add("np_e0_b",      0, 8'h80, 0, 8'h44, 1, 3'd2);
        add("np_e0_ack",    0, 8'h80, 1, 8'h40, 0, 3'd0);
        add("np_e0_idle",   0, 8'h00, 0, 8'h40, 0, 3'd0);
        add("np_e1_pres",   1, 8'h00, 0, 8'h40, 1, 3'd6);
        add("np_e1_ack",    1, 8'h00, 1, 8'h00, 0, 3'd0);
        // set-wins collision
        add("col_cap",      1, 8'h10, 0, 8'h10, 0, 3'd0);
        add("col_pres",     1, 8'h00, 0, 8'h10, 1, 3'd4);
        add("col_hit",      1, 8'h10, 1, 8'h10, 0, 3'd0);
        add("col_repres",   1, 8'h00, 0, 8'h10, 1, 3'd4);
        add("col_ack",      1, 8'h00, 1, 8'h00, 0, 3'd0);

        reset = 1'b1;
        E     = 1'b0;
        Req   = 8'h00;
        Ack   = 1'b0;
        repeat (2) step();
        check8("rst_pend",  Pending, 8'h00);
        check8("rst_valid", {7'd0, Valid}, 8'h00);
        check8("rst_code",  {5'd0, Code}, 8'h00);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            E   = vecs[i].e;
            Req = vecs[i].req;
            Ack = vecs[i].ack;
            step();
            check8({vecs[i].name, "_pend"}, Pending, vecs[i].exp_pend);
            check8({vecs[i].name, "_valid"}, {7'd0, Valid},
                   {7'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                check8({vecs[i].name, "_code"}, {5'd0, Code},
                       {5'd0, vecs[i].exp_code});
        end

        // asynchronous reset mid-GRANT with Pending=81
        E   = 1'b1;
        Req = 8'h81;
        Ack = 1'b0;
        step();
        Req = 8'h00;
        step();
        check8("mid_pres_valid", {7'd0, Valid}, 8'h01);
        check8("mid_pres_code",  {5'd0, Code}, 8'h07);
        check8("mid_pres_pend",  Pending, 8'h81);
        #1 reset = 1'b1;
        #1;
        check8("async_valid", {7'd0, Valid}, 8'h00);
        check8("async_code",  {5'd0, Code}, 8'h00);
        check8("async_pend",  Pending, 8'h00);
        step();
        #2 reset = 1'b0;
        repeat (2) step();
        check8("post_rst_valid", {7'd0, Valid}, 8'h00);
        check8("post_rst_pend",  Pending, 8'h00);

        // Ack while idle is ignored
        for (int k = 0; k < 2; k++) begin
            E   = k[0] ? 1'b0 : 1'b1;
            Ack = 1'b1;
            step();
            Ack = 1'b0;
            step();
            check8("idle_ack_valid", {7'd0, Valid}, 8'h00);
            check8("idle_ack_code",  {5'd0, Code}, 8'h00);
            check8("idle_ack_pend",  Pending, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
